pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised fetch/decode pipeline stage register carrying {pc, inst} with
//  valid/ready handshake, 2-entry skid buffer, synchronous flush and NOP bubble
//  output. Replaces fixed IF/ID latching: stall now HOLDS contents (back-pressure
//  via out_ready) instead of clearing. Flush on branch-taken/redirect squashes all.
//  Saturating perf counters expose stall and flush activity to the debug CSR file.
// PARAMETERS
//  ADDR_W    32            PC width
//  INST_W    32            instruction width
//  NOP_INST  32'h00000013  instruction driven when out_valid=0 (addi x0,x0,0)
//  SKID      1             1: 2-entry skid (registered in_ready); 0: single entry
//  CNT_W     16            width of perf counters (saturating)
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       squash all held entries this cycle
//  in_valid   in   1       upstream {in_pc,in_inst} valid
//  in_ready   out  1       stage can accept this cycle
//  in_pc      in   ADDR_W  fetch PC
//  in_inst    in   INST_W  fetched instruction
//  out_valid  out  1       downstream entry valid
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_pc     out  ADDR_W  PC of head entry; 0 when out_valid=0
//  out_inst   out  INST_W  head instruction; NOP_INST when out_valid=0
//  stall_cnt  out  CNT_W   cycles with out_valid & ~out_ready
//  flush_cnt  out  CNT_W   cycles with flush & (any entry valid)
// BEHAVIOUR
//  - Clock clk; reset synchronous, active-high, highest priority.
//  - Reset: state EMPTY, out_valid=0, out_pc=0, out_inst=NOP_INST, counters=0,
//    in_ready=1 the cycle after reset deasserts; inputs during reset ignored.
//  - accept = in_valid & in_ready; drain = out_valid & out_ready.
//  - Latency 1 cycle: entry accepted at edge N is visible at out_* after edge N.
//  - FIFO order preserved; no entry duplicated or dropped except by flush.
//  - SKID=1 states (main = head register, skid = overflow register):
//    EMPTY: accept -> ONE (main<=in).
//    ONE:   accept&~drain -> TWO (skid<=in); accept&drain -> ONE (main<=in);
//           ~accept&drain -> EMPTY; else hold.
//    TWO:   in_ready=0; drain -> ONE (main<=skid); else hold.
//    in_ready = (state!=TWO), registered; no combinational path from out_ready.
//  - SKID=0: single entry; in_ready = ~out_valid | out_ready (combinational);
//    accept & drain same cycle replaces entry.
//  - Hold: while out_valid & ~out_ready, out_pc/out_inst stable every cycle.
//  - Flush (priority over accept/drain, below reset): next state EMPTY, both
//    entries invalidated, out_* return to 0/NOP_INST; in_valid that cycle is
//    dropped even if in_ready=1. in_ready=1 next cycle.
//  - Invalid slots: pc forced 0, inst forced NOP_INST (no X propagation).
//  - Counters: +1 per qualifying cycle, saturate at all-ones, never wrap;
//    flush with state EMPTY does not count; cleared only by reset.
//  - Simultaneous flush & out_ready: drain still counted as consumed by
//    downstream for that cycle; post-edge state EMPTY.
// TESTING
//  1 reset 2 cyc -> out_valid=0, out_inst=0x00000013, out_pc=0, in_ready=1, cnts=0.
//  2 push pc=0x100/inst=0x00500093, out_ready=1 -> next cycle out_pc=0x100,
//    out_inst=0x00500093; stream 8 back-to-back, 1/cycle throughput, in order.
//  3 out_ready=0, push 0x100,0x104 -> TWO, in_ready=0; 5 held cycles stall_cnt=5,
//    out_pc=0x100 stable; release -> 0x100 then 0x104, in_ready=1 again.
//  4 in TWO assert flush with in_valid (pc=0x200) -> next cycle out_valid=0,
//    out_inst=NOP, 0x200 not emitted, flush_cnt=1; flush while EMPTY -> cnt stays 1.
//  5 CNT_W=4, hold stall 20 cycles -> stall_cnt=15 (saturated, no wrap).
//  6 SKID=0: out_ready=0 with entry -> in_ready=0 same cycle; random valid/ready
//    1e4 cycles vs scoreboard -> no loss/dup, order preserved.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready channel carrying one {pc, inst} pipeline entry.
// master drives the payload, slave returns ready.
interface pipe_stage_skid_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] pc;
   logic [INST_W-1:0] inst;

   modport master (output valid, output pc, output inst, input ready);
   modport slave  (input valid, input pc, input inst, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Fetch/decode stage register with optional 2-entry skid, flush squash,
// NOP bubble on empty and saturating stall/flush perf counters.
module pipe_stage_skid #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        INST_W   = 32,
   parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013),
   parameter bit                 SKID     = 1'b1,
   parameter int unsigned        CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   pipe_stage_skid_if.slave     up_if,
   pipe_stage_skid_if.master    dn_if,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   logic              head_valid_q;
   logic [ADDR_W-1:0] head_pc_q;
   logic [INST_W-1:0] head_inst_q;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic [CNT_W-1:0]  flush_cnt_q;
   logic              accept_c;
   logic              drain_c;

   assign accept_c   = up_if.valid & up_if.ready;
   assign drain_c    = head_valid_q & dn_if.ready;

   assign dn_if.valid = head_valid_q;
   assign dn_if.pc    = head_pc_q;
   assign dn_if.inst  = head_inst_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

   // Perf counters saturate at all-ones; the head slot is valid whenever any entry is.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (head_valid_q && !dn_if.ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush && head_valid_q && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   if (SKID) begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

      state_e            state_q;
      logic [ADDR_W-1:0] skid_pc_q;
      logic [INST_W-1:0] skid_inst_q;
      logic              in_ready_q;

      assign up_if.ready = in_ready_q;

      // Head/skid FSM; empty slots are parked at 0/NOP so no X reaches downstream.
      always_ff @(posedge clk) begin
         if (reset || flush) begin
            state_q      <= EMPTY;
            head_valid_q <= 1'b0;
            head_pc_q    <= '0;
            head_inst_q  <= NOP_INST;
            skid_pc_q    <= '0;
            skid_inst_q  <= NOP_INST;
            in_ready_q   <= 1'b1;
         end else begin
            case (state_q)
               EMPTY: begin
                  if (accept_c) begin
                     state_q      <= ONE;
                     head_valid_q <= 1'b1;
                     head_pc_q    <= up_if.pc;
                     head_inst_q  <= up_if.inst;
                  end
               end
               ONE: begin
                  if (accept_c && !drain_c) begin
                     state_q     <= TWO;
                     skid_pc_q   <= up_if.pc;
                     skid_inst_q <= up_if.inst;
                     in_ready_q  <= 1'b0;
                  end else if (accept_c && drain_c) begin
                     head_pc_q   <= up_if.pc;
                     head_inst_q <= up_if.inst;
                  end else if (drain_c) begin
                     state_q      <= EMPTY;
                     head_valid_q <= 1'b0;
                     head_pc_q    <= '0;
                     head_inst_q  <= NOP_INST;
                  end
               end
               TWO: begin
                  if (drain_c) begin
                     state_q     <= ONE;
                     head_pc_q   <= skid_pc_q;
                     head_inst_q <= skid_inst_q;
                     skid_pc_q   <= '0;
                     skid_inst_q <= NOP_INST;
                     in_ready_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q      <= EMPTY;
                  head_valid_q <= 1'b0;
                  head_pc_q    <= '0;
                  head_inst_q  <= NOP_INST;
                  in_ready_q   <= 1'b1;
               end
            endcase
         end
      end
   end else begin : g_single
      // Single entry: ready passes straight through from downstream.
      assign up_if.ready = ~head_valid_q | dn_if.ready;

      always_ff @(posedge clk) begin
         if (reset || flush) begin
            head_valid_q <= 1'b0;
            head_pc_q    <= '0;
            head_inst_q  <= NOP_INST;
         end else if (accept_c) begin
            head_valid_q <= 1'b1;
            head_pc_q    <= up_if.pc;
            head_inst_q  <= up_if.inst;
         end else if (drain_c) begin
            head_valid_q <= 1'b0;
            head_pc_q    <= '0;
            head_inst_q  <= NOP_INST;
         end
      end
   end

endmodule
